// File: rtl/seq_pattern_pkg.sv
// Shared definitions for the serial pattern transmitter and the benches that observe it.
// State encodings are fixed so detector benches can bin state coverage by value.
package seq_pattern_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_GAP   = 2'd2
    } state_e;

    // Gap counter width: enough bits to hold GAP_CYCLES-1, never less than one bit.
    function automatic int gap_cnt_width(input int gap_cycles);
        return (gap_cycles < 2) ? 1 : $clog2(gap_cycles + 1);
    endfunction

endpackage

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: accepts a word via valid/ready, shifts it out MSB-first,
// then forces GAP_CYCLES zero bits so every run of 1s ends before the next frame.
module seq_pattern_tx
    import seq_pattern_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int GAP_CYCLES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    output logic             out,
    output logic             out_valid,
    output logic             busy,
    output logic             done
);

    localparam int BW = $clog2(WIDTH);
    localparam int GW = gap_cnt_width(GAP_CYCLES);
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
    localparam logic [GW-1:0] GAP_LAST = (GAP_CYCLES > 0) ? GW'(GAP_CYCLES - 1) : {GW{1'b0}};
    localparam bit            HAS_GAP  = (GAP_CYCLES > 0);

    state_e           state_r, state_s;
    logic [WIDTH-1:0] shreg_r, shreg_s;
    logic [BW-1:0]    bitcnt_r, bitcnt_s;
    logic [GW-1:0]    gapcnt_r, gapcnt_s;
    logic             done_s;
    logic             out_s;
    logic             out_valid_s;
    logic             busy_s;
    logic             load_ready_s;
    logic             transfer_s;

    assign transfer_s = load_valid & load_ready;

    // Next-state, datapath and output decode; outputs are taken from the next state so
    // they can be registered without adding a cycle of latency.
    always_comb begin
        state_s  = state_r;
        shreg_s  = shreg_r;
        bitcnt_s = bitcnt_r;
        gapcnt_s = gapcnt_r;
        done_s   = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (transfer_s) begin
                    state_s  = S_SHIFT;
                    shreg_s  = load_data;
                    bitcnt_s = BIT_LAST;
                end else begin
                    state_s  = S_IDLE;
                end
            end
            S_SHIFT: begin
                shreg_s = shreg_r << 1;
                if (bitcnt_r != {BW{1'b0}}) begin
                    bitcnt_s = bitcnt_r - BW'(1);
                end else if (HAS_GAP) begin
                    state_s  = S_GAP;
                    gapcnt_s = GAP_LAST;
                end else begin
                    // No gap: the frame is complete now and a new word may chain in.
                    done_s = 1'b1;
                    if (transfer_s) begin
                        state_s  = S_SHIFT;
                        shreg_s  = load_data;
                        bitcnt_s = BIT_LAST;
                    end else begin
                        state_s  = S_IDLE;
                    end
                end
            end
            S_GAP: begin
                if (gapcnt_r != {GW{1'b0}}) begin
                    gapcnt_s = gapcnt_r - GW'(1);
                end else begin
                    state_s = S_IDLE;
                    done_s  = 1'b1;
                end
            end
            default: begin
                state_s  = S_IDLE;
                shreg_s  = {WIDTH{1'b0}};
                bitcnt_s = {BW{1'b0}};
                gapcnt_s = {GW{1'b0}};
            end
        endcase

        out_valid_s  = (state_s == S_SHIFT);
        out_s        = shreg_s[WIDTH-1] & out_valid_s;
        busy_s       = (state_s != S_IDLE);
        load_ready_s = (state_s == S_IDLE) |
                       ((state_s == S_SHIFT) & (bitcnt_s == {BW{1'b0}}) & !HAS_GAP);
    end

    // State, datapath and registered outputs; reset aborts any frame in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r    <= S_IDLE;
            shreg_r    <= {WIDTH{1'b0}};
            bitcnt_r   <= {BW{1'b0}};
            gapcnt_r   <= {GW{1'b0}};
            out        <= 1'b0;
            out_valid  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            load_ready <= 1'b1;
        end else begin
            state_r    <= state_s;
            shreg_r    <= shreg_s;
            bitcnt_r   <= bitcnt_s;
            gapcnt_r   <= gapcnt_s;
            out        <= out_s;
            out_valid  <= out_valid_s;
            busy       <= busy_s;
            done       <= done_s;
            load_ready <= load_ready_s;
        end
    end

endmodule
